// File: rtl/uart_rx.sv
// 8N1 UART receiver for the clk_3125 domain with a start-bit-aligned mid-bit sampler.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int SYS_CLK   = 3125000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_3125,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync_ff;
    logic                 rx_s;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 bit_end;
    logic                 half_end;

    assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_end = (clk_cnt == CNT_W'(HALF_BIT - 1));
    assign busy     = (state != IDLE);

    // Synchronizer resets to 1 so the line looks idle straight out of reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_ff <= rx_in;
            rx_s    <= sync_ff;
        end
    end

    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s)    state_next = START;
            START:   if (half_end) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_end && bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:  if (bit_end)  state_next = STOP;
`endif
            STOP:    if (bit_end)  state_next = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s)     state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Counters only run in the timed states, so IDLE and BREAK never wrap them.
    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (state_next != state || bit_end)
                clk_cnt <= '0;
            else if (state != IDLE && state != BREAK)
                clk_cnt <= clk_cnt + CNT_W'(1);

            if (state_next != state)
                bit_idx <= '0;
            else if (state == DATA && bit_end)
                bit_idx <= bit_idx + IDX_W'(1);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
`endif

    always_ff @(posedge clk_3125 or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            if (state == PARITY && bit_end)
                parity_bad <= (^shift_reg) ^ rx_s;
`endif
            // LSB arrives first: shifting right leaves it at bit 0 after the last data bit.
            if (state == DATA && bit_end)
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};

            if (state == STOP && bit_end) begin
                if (rx_s) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err <= parity_bad;
`endif
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
